// File: rtl/router_sync_n_if.sv
// Bundle of router control signals between the packet FSM/FIFO side and the sync block.
// The master modport drives the inputs and the slave modport is the router itself.
interface router_sync_n_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic              addr_err;

  modport master (
    output detect_add, data_in, write_enb_reg, full, empty, read_enb,
    input  write_enb, fifo_full, vld_out, soft_reset, addr_err
  );

  modport slave (
    input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
    output write_enb, fifo_full, vld_out, soft_reset, addr_err
  );
endinterface

// File: rtl/router_sync_n.sv
// Router synchroniser: latches the packet destination, steers FIFO write enables,
// reports per-channel valid, and flushes any FIFO whose data sits unread too long.
module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input logic            clock,
  input logic            reset,
  router_sync_n_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] addr;
  logic              addr_err;
  logic [NUM_CH-1:0] sel;

  always_ff @(posedge clock) begin
    if (reset) begin
      addr     <= '0;
      addr_err <= 1'b0;
    end else if (bus.detect_add) begin
      addr     <= bus.data_in;
      addr_err <= (32'(bus.data_in) >= NUM_CH);
    end
  end

  // Decode uses the already-latched address, so a header arriving alongside a
  // write request never redirects that write.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sel
    assign sel[i] = (addr == ADDR_W'(i)) && !addr_err;
  end

  assign bus.write_enb = bus.write_enb_reg ? sel : '0;
  assign bus.fifo_full = |(bus.full & sel);
  assign bus.vld_out   = ~bus.empty;
  assign bus.addr_err  = addr_err;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_timer
    logic [CNT_W-1:0] cnt;
    logic             flush;
    logic             stall;

    assign stall = bus.vld_out[i] && !bus.read_enb[i];

    // Terminal count clears the counter, so the flush repeats every TIMEOUT
    // cycles while the channel stays stalled; any read restarts the window.
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt   <= '0;
        flush <= 1'b0;
      end else if (stall) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          flush <= 1'b1;
        end else begin
          cnt   <= cnt + 1'b1;
          flush <= 1'b0;
        end
      end else begin
        cnt   <= '0;
        flush <= 1'b0;
      end
    end

    assign bus.soft_reset[i] = flush;
  end
endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: table-driven address/steering vectors, then timeout
// sequences whose expected soft_reset values go through a scoreboard queue.
module tb_router_sync_n;
  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  router_sync_n_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  router_sync_n #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       da;
    logic [1:0] din;
    logic       wr;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] exp_we;
    logic       exp_ff;
    logic [2:0] exp_vld;
    logic       exp_ae;
  } vec_t;

  vec_t       vecs[11];
  logic [2:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.empty = 3'b111;
    bus.read_enb = 3'b000;
    cyc();
    reset = 1'b0;
  endtask

  // Hold empty at emp for n edges; optional single-cycle read on channel 1 and
  // single-cycle reset; expected pulse value pv after edges p1 and p2.
  task automatic run_seq(input string name, input int n, input int read_c, input int rst_c,
                         input logic [2:0] emp, input int p1, input int p2, input logic [2:0] pv);
    logic [2:0] exp;
    bus.empty = emp;
    for (int c = 1; c <= n; c++) begin
      reset = (c == rst_c);
      bus.read_enb = (c == read_c) ? 3'b010 : 3'b000;
      sb_q.push_back((c == p1 || c == p2) ? pv : 3'b000);
      cyc();
      exp = sb_q.pop_front();
      check($sformatf("%s_c%0d", name, c), 32'(bus.soft_reset), 32'(exp));
    end
    reset = 1'b0;
    bus.read_enb = 3'b000;
  endtask

  initial begin
    //          da  din   wr  full    empty   we      ff  vld     ae
    vecs[0]  = '{0, 2'd0, 1, 3'b000, 3'b111, 3'b001, 0, 3'b000, 0};
    vecs[1]  = '{1, 2'd1, 0, 3'b010, 3'b110, 3'b000, 0, 3'b001, 0};
    vecs[2]  = '{0, 2'd0, 1, 3'b010, 3'b101, 3'b010, 1, 3'b010, 0};
    vecs[3]  = '{0, 2'd0, 1, 3'b000, 3'b011, 3'b010, 0, 3'b100, 0};
    vecs[4]  = '{1, 2'd3, 1, 3'b111, 3'b111, 3'b010, 1, 3'b000, 0};
    vecs[5]  = '{0, 2'd0, 1, 3'b111, 3'b111, 3'b000, 0, 3'b000, 1};
    vecs[6]  = '{1, 2'd2, 0, 3'b111, 3'b000, 3'b000, 0, 3'b111, 1};
    vecs[7]  = '{0, 2'd0, 1, 3'b100, 3'b111, 3'b100, 1, 3'b000, 0};
    vecs[8]  = '{0, 2'd0, 1, 3'b011, 3'b111, 3'b100, 0, 3'b000, 0};
    vecs[9]  = '{1, 2'd0, 0, 3'b001, 3'b111, 3'b000, 0, 3'b000, 0};
    vecs[10] = '{0, 2'd0, 1, 3'b001, 3'b111, 3'b001, 1, 3'b000, 0};

    reset = 1'b1;
    bus.detect_add = 1'b1;
    bus.data_in = 2'd1;
    bus.write_enb_reg = 1'b1;
    bus.full = 3'b000;
    bus.empty = 3'b111;
    bus.read_enb = 3'b000;
    cyc();
    cyc();
    check("rst_addr_err", 32'(bus.addr_err), 32'd0);
    check("rst_soft_reset", 32'(bus.soft_reset), 32'd0);
    check("rst_write_enb", 32'(bus.write_enb), 32'b001);
    reset = 1'b0;
    bus.detect_add = 1'b0;

    for (int i = 0; i < 11; i++) begin
      bus.detect_add = vecs[i].da;
      bus.data_in = vecs[i].din;
      bus.write_enb_reg = vecs[i].wr;
      bus.full = vecs[i].full;
      bus.empty = vecs[i].empty;
      #1;
      check($sformatf("vec%0d_write_enb", i), 32'(bus.write_enb), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_fifo_full", i), 32'(bus.fifo_full), 32'(vecs[i].exp_ff));
      check($sformatf("vec%0d_vld_out", i), 32'(bus.vld_out), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_addr_err", i), 32'(bus.addr_err), 32'(vecs[i].exp_ae));
      cyc();
    end
    bus.detect_add = 1'b0;
    bus.write_enb_reg = 1'b0;

    do_reset();
    run_seq("hold", 65, 0, 0, 3'b101, 30, 60, 3'b010);
    do_reset();
    run_seq("read30", 65, 30, 0, 3'b101, 60, -1, 3'b010);
    do_reset();
    run_seq("rst20", 55, 0, 20, 3'b000, 50, -1, 3'b111);

    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
